// File: rtl/serial_to_ports.sv
// serial_to_ports
// Collects a serial bit stream into WIDTH-bit parallel words and hands each
// word to a downstream port-consumer stage with a valid/ready handshake.
// A frame is WIDTH bits, first bit landing in pout_data[0].
// Optional build macro SERIAL_TO_PORTS_PARITY_EN: each frame carries one extra
// even-parity bit after the data bits; a bad frame pulses par_err and is dropped.

module serial_to_ports #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic             pout_valid,
    output logic [WIDTH-1:0] pout_data,
    input  logic             pout_ready,
    output logic [7:0]       frame_cnt,
    output logic             par_err
);

`ifdef SERIAL_TO_PORTS_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ready_q;
    logic [7:0]       frame_q;

    logic accept;
    logic last_bit;
    logic handshake;
    logic par_bad;

    assign accept    = sin_valid && ready_q;
    assign last_bit  = accept && (bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign handshake = valid_q && pout_ready;

`ifdef SERIAL_TO_PORTS_PARITY_EN
    logic par_acc;
    logic par_err_q;

    // The final frame bit must equal the XOR of the data bits (even parity).
    assign par_bad = last_bit && (sin_data != par_acc);

    // Running parity of the data bits, plus a one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_bad;
            if (last_bit) begin
                par_acc <= 1'b0;
            end else if (accept) begin
                par_acc <= par_acc ^ sin_data;
            end
        end
    end

    assign par_err = par_err_q;
`else
    assign par_bad = 1'b0;
    assign par_err = 1'b0;
`endif

    // Next-state logic; a bad-parity frame skips HOLD and goes straight back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = par_bad ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, bit counter, word register, handshake flags and delivered-word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            frame_q <= 8'd0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != HOLD);

            if (state_nxt == IDLE) begin
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            for (int k = 0; k < WIDTH; k++) begin
                if (accept && (bit_cnt == CNT_W'(k))) begin
                    data_q[k] <= sin_data;
                end
            end

            if (handshake) begin
                valid_q <= 1'b0;
            end else if (last_bit && !par_bad) begin
                valid_q <= 1'b1;
            end

            if (handshake) begin
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    assign sin_ready  = ready_q;
    assign pout_valid = valid_q;
    assign pout_data  = data_q;
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_serial_to_ports.sv
// tb_serial_to_ports
// Directed stimulus pushes the expected word into a scoreboard queue; a
// monitor pops and compares on every pout handshake. Parity cases are built
// when SERIAL_TO_PORTS_PARITY_EN is defined.

module tb_serial_to_ports;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             sin_ready;
    logic             pout_valid;
    logic [WIDTH-1:0] pout_data;
    logic             pout_ready = 1'b0;
    logic [7:0]       frame_cnt;
    logic             par_err;

    int tests_run = 0;
    int tests_failed = 0;
    int words_seen = 0;

    logic [7:0]       exp_frames = 8'd0;
    logic [WIDTH-1:0] mon_exp;
    logic [WIDTH-1:0] sb[$];

    serial_to_ports #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .sin_ready  (sin_ready),
        .pout_valid (pout_valid),
        .pout_data  (pout_data),
        .pout_ready (pout_ready),
        .frame_cnt  (frame_cnt),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports actual vs required on a miss.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Offer one serial bit and wait (bounded) until it is accepted.
    task automatic send_bit(input logic b);
        bit got;
        got = 1'b0;
        sin_valid = 1'b1;
        sin_data  = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sin_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) report_timeout("sin_accept");
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
    endtask

    // Send a full frame (parity appended when enabled), expecting word d.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input int gap);
        sb.push_back(d);
        for (int k = 0; k < WIDTH; k++) begin
            send_bit(d[k]);
            if (k < WIDTH - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
`ifdef SERIAL_TO_PORTS_PARITY_EN
        send_bit(^d);
`endif
    endtask

    // Raise pout_ready until the monitor has seen 'target' words in total.
    task automatic wait_delivery(input int target);
        bit got;
        got = 1'b0;
        pout_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (words_seen >= target) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) report_timeout("delivery");
        pout_ready = 1'b0;
    endtask

    // Monitor: every handshake must match the oldest expected word and count.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_frames = 8'd0;
        end else if (pout_valid && pout_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", pout_data);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("word_data", {28'd0, pout_data}, {28'd0, mon_exp});
            end
            checkOutput("frame_cnt_at_handshake", {24'd0, frame_cnt}, {24'd0, exp_frames});
            exp_frames = exp_frames + 8'd1;
            words_seen++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        checkOutput("rst_sin_ready", {31'd0, sin_ready}, 32'd0);
        checkOutput("rst_pout_valid", {31'd0, pout_valid}, 32'd0);
        checkOutput("rst_pout_data", {28'd0, pout_data}, 32'd0);
        checkOutput("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        checkOutput("rst_par_err", {31'd0, par_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", {31'd0, sin_ready}, 32'd1);

        // Back-to-back frame 1,0,1,1 -> 4'b1101, valid the next cycle
        applyStimulus(4'b1101, 0);
        checkOutput("b2b_valid", {31'd0, pout_valid}, 32'd1);
        checkOutput("b2b_data", {28'd0, pout_data}, 32'hD);
        checkOutput("b2b_ready_low", {31'd0, sin_ready}, 32'd0);

        // Held word with pout_ready low and sin_valid high for 5 cycles
        sin_valid = 1'b1;
        sin_data  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_data", {28'd0, pout_data}, 32'hD);
            checkOutput("hold_valid", {31'd0, pout_valid}, 32'd1);
            checkOutput("hold_ready", {31'd0, sin_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        wait_delivery(1);
        checkOutput("post_hs_valid", {31'd0, pout_valid}, 32'd0);
        checkOutput("post_hs_ready", {31'd0, sin_ready}, 32'd1);
        checkOutput("frame_cnt_1", {24'd0, frame_cnt}, 32'd1);

        // Bits 0,1,1,0 with 3 idle cycles between -> 4'b0110, one word
        applyStimulus(4'b0110, 3);
        checkOutput("gap_valid", {31'd0, pout_valid}, 32'd1);
        checkOutput("gap_data", {28'd0, pout_data}, 32'h6);
        wait_delivery(2);
        checkOutput("gap_word_count", words_seen, 32'd2);
        checkOutput("frame_cnt_2", {24'd0, frame_cnt}, 32'd2);

        // Reset after 2 bits, then 0,0,0,1 -> single word 4'b1000
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_sin_ready", {31'd0, sin_ready}, 32'd0);
        checkOutput("midrst_pout_data", {28'd0, pout_data}, 32'd0);
        checkOutput("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_back", {31'd0, sin_ready}, 32'd1);
        applyStimulus(4'b1000, 0);
        wait_delivery(3);
        checkOutput("midrst_word_count", words_seen, 32'd3);
        checkOutput("midrst_frame_cnt_1", {24'd0, frame_cnt}, 32'd1);

`ifdef SERIAL_TO_PORTS_PARITY_EN
        // 1,0,1,1 with wrong parity 0: error pulse, frame dropped
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checkOutput("perr_pulse", {31'd0, par_err}, 32'd1);
        checkOutput("perr_no_valid", {31'd0, pout_valid}, 32'd0);
        checkOutput("perr_ready", {31'd0, sin_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("perr_pulse_end", {31'd0, par_err}, 32'd0);
        checkOutput("perr_still_no_valid", {31'd0, pout_valid}, 32'd0);
        checkOutput("perr_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        // Same data with correct parity 1 -> word 4'b1101
        applyStimulus(4'b1101, 0);
        checkOutput("pok_valid", {31'd0, pout_valid}, 32'd1);
        checkOutput("pok_data", {28'd0, pout_data}, 32'hD);
        checkOutput("pok_par_err", {31'd0, par_err}, 32'd0);
        wait_delivery(4);
        checkOutput("pok_frame_cnt", {24'd0, frame_cnt}, 32'd2);
`else
        checkOutput("par_err_tied", {31'd0, par_err}, 32'd0);
`endif

        // 256 frames of 4'b0000 from reset: frame_cnt wraps back to 0
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin
            int base;
            bit got;
            base = words_seen;
            got = 1'b0;
            pout_ready = 1'b1;
            for (int f = 0; f < 256; f++) begin
                applyStimulus(4'b0000, 0);
            end
            for (int n = 0; n < 50; n++) begin
                @(posedge clk);
                #1;
                if (words_seen >= base + 256) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) report_timeout("wrap_delivery");
            pout_ready = 1'b0;
            checkOutput("wrap_word_count", words_seen - base, 32'd256);
            checkOutput("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_to_ports.md
SERIAL_TO_PORTS -- requirements
Module: serial_to_ports

Interface
REQ-001 SHALL have parameter: WIDTH, 4, number of parallel port bits delivered per frame (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: sin_valid  input  1  serial bit offered this cycle.
REQ-005 SHALL have port: sin_data  input  1  serial bit value, first bit = pout_data[0].
REQ-006 SHALL have port: sin_ready  output  1  block accepts serial bit this cycle.
REQ-007 SHALL have port: pout_valid  output  1  parallel word held for downstream port-consumer stage.
REQ-008 SHALL have port: pout_data  output  WIDTH  parallel word driven onto downstream input ports.
REQ-009 SHALL have port: pout_ready  input  1  downstream takes word this cycle.
REQ-010 SHALL have port: frame_cnt  output  8  count of words delivered, wraps.
REQ-011 SHALL have port: par_err  output  1  parity failure pulse (tied 0 without macro).

Function
REQ-012 SHALL transfer a serial bit only when sin_valid && sin_ready at rising clk.
REQ-013 SHALL implement states IDLE, SHIFT, HOLD; IDLE->SHIFT on first accepted bit, SHIFT->HOLD on last frame bit accepted, HOLD->IDLE on pout_valid && pout_ready.
REQ-014 SHALL load bit k of the frame (k = 0 first) into pout_data[k]; no reordering.
REQ-015 SHALL assert pout_valid the cycle after the last frame bit is accepted (latency 1 cycle).
REQ-016 SHALL drive sin_ready = 1 in IDLE and SHIFT, 0 in HOLD; no bit accepted while a word is held.
REQ-017 SHALL keep pout_data and pout_valid stable in HOLD until pout_ready is sampled high.
REQ-018 SHALL deassert pout_valid the cycle after the handshake and reassert sin_ready that same cycle.
REQ-019 SHALL tolerate sin_valid gaps of any length in SHIFT without losing or duplicating bits.
REQ-020 SHALL count accepted bits with a counter of clog2(WIDTH+2) bits, cleared on entry to IDLE.
REQ-021 SHALL increment frame_cnt by 1 on each pout handshake, modulo 256 (255 -> 0).
REQ-022 SHALL ignore pout_ready while pout_valid is 0.

Reset
REQ-023 SHALL on rst_n low immediately force state IDLE, bit counter 0, pout_data 0, pout_valid 0, frame_cnt 0, par_err 0, sin_ready 0.
REQ-024 SHALL drive sin_ready 1 from the first rising clk after rst_n deasserts.
REQ-025 SHALL discard any partial frame or held word when reset asserts mid-operation; no word is delivered from it.

Configuration
REQ-026 SHALL, with macro SERIAL_TO_PORTS_PARITY_EN defined, expect WIDTH+1 bits per frame, last being even-parity over the WIDTH data bits.
REQ-027 SHALL, with macro defined, on parity mismatch pulse par_err high for exactly 1 cycle after the parity bit, skip HOLD, return to IDLE, leave frame_cnt unchanged.
REQ-028 SHALL, with macro defined and parity correct, behave per REQ-015 counted from the parity bit.
REQ-029 SHALL, without macro, use WIDTH bits per frame and tie par_err to 0.

Verification
REQ-030 SHALL cover: WIDTH=4, bits 1,0,1,1 back-to-back -> pout_valid=1 next cycle, pout_data=4'b1101, frame_cnt 0->1 on handshake.
REQ-031 SHALL cover: word held, pout_ready low 5 cycles, sin_valid=1 -> pout_data stable 4'b1101, sin_ready=0, no bit consumed.
REQ-032 SHALL cover: bits 0,1,1,0 with 3 idle cycles between each -> pout_data=4'b0110, exactly one word.
REQ-033 SHALL cover: rst_n pulsed low after 2 bits, then bits 0,0,0,1 -> single word 4'b1000, frame_cnt=1.
REQ-034 SHALL cover: 256 frames of 4'b0000 with pout_ready=1 -> frame_cnt reads 0 after last handshake.
REQ-035 SHALL cover (macro defined): bits 1,0,1,1 + parity 0 -> par_err 1-cycle pulse, pout_valid stays 0; same with parity 1 -> pout_data=4'b1101.
